// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side consumer presenting popped words as a framed valid/ready stream
module fifo_rd_stream #(
    parameter int DATA_LEN = 32,
    parameter int PKT_LEN  = 16,
    parameter int CNT_LEN  = 32
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                en_i,
    output logic                read_en_o,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic                rempty_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [DATA_LEN-1:0] m_data_o,
    output logic                m_last_o,
    output logic [CNT_LEN-1:0]  word_count_o,
    output logic                busy_o
);

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                occ;
    logic                rd_pend;
    logic [DATA_LEN-1:0] head;
    logic [DATA_LEN-1:0] tail;
    logic [BW-1:0]       beat_idx;
    logic                pop_out;
    logic [2:0]          credits;

    // Slots already committed (held + in flight) must leave room for one more
    // word after this cycle's output pop, so the 2-entry buffer never overflows.
    always_comb begin
        pop_out   = m_valid_o & m_ready_i;
        credits   = {1'b0, occ} + {2'b00, rd_pend};
        read_en_o = !rst & en_i & !rempty_i & (credits < (3'd2 + {2'b00, pop_out}));
        m_valid_o = (occ != EMPTY);
        m_data_o  = head;
        m_last_o  = m_valid_o & (beat_idx == LAST_IDX);
        busy_o    = m_valid_o | rd_pend;
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            occ          <= EMPTY;
            rd_pend      <= 1'b0;
            head         <= '0;
            tail         <= '0;
            beat_idx     <= '0;
            word_count_o <= '0;
        end else begin
            rd_pend <= read_en_o;

            if (read_en_o && (word_count_o != '1)) begin
                word_count_o <= word_count_o + 1'b1;
            end

            if (pop_out) begin
                beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
            end

            // rd_pend marks the cycle in which rdata_i carries the word popped last cycle.
            case (occ)
                EMPTY: begin
                    if (rd_pend) begin
                        head <= rdata_i;
                        occ  <= ONE;
                    end
                end
                ONE: begin
                    if (rd_pend && !pop_out) begin
                        tail <= rdata_i;
                        occ  <= TWO;
                    end else if (rd_pend && pop_out) begin
                        head <= rdata_i;
                    end else if (pop_out) begin
                        occ <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop_out) begin
                        head <= tail;
                        if (rd_pend) begin
                            tail <= rdata_i;
                        end else begin
                            occ <= ONE;
                        end
                    end
                end
                default: occ <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream against a queue model
module tb_fifo_rd_stream;

    localparam int DW = 32;
    localparam int PL = 16;
    localparam int CW = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          rclk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b0;
    logic          read_en_o;
    logic [DW-1:0] rdata_i = '0;
    logic          rempty_i = 1'b1;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic [CW-1:0] word_count_o;
    logic          busy_o;

    fifo_rd_stream #(.DATA_LEN(DW), .PKT_LEN(PL), .CNT_LEN(CW)) dut (
        .rclk(rclk), .rst(rst), .en_i(en_i), .read_en_o(read_en_o),
        .rdata_i(rdata_i), .rempty_i(rempty_i), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .word_count_o(word_count_o), .busy_o(busy_o)
    );

    always #5 rclk = ~rclk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            total_pops = 0;
    int            beat_cnt = 0;
    logic [DW-1:0] next_val = '0;
    bit            pend_pop = 1'b0;
    logic [DW-1:0] pend_word = '0;

    bit            f, l, el;
    logic [DW-1:0] d, ed;

    // FIFO model + reference: words leave fifo_q on a real pop, show up on rdata_i
    // one cycle later, and must come out of the stream in the same order.
    task automatic tick(input bit r, input bit rdy, input bit en, input bit hold,
                        output bit fired, output logic [DW-1:0] dd, output bit ll,
                        output logic [DW-1:0] edd, output bit ell);
        @(negedge rclk);
        rdata_i   = pend_pop ? pend_word : DW'($urandom);
        pend_pop  = 1'b0;
        rst       = r;
        m_ready_i = rdy;
        en_i      = en;
        rempty_i  = hold || (fifo_q.size() == 0);
        #1;
        fired = !r && m_valid_o && m_ready_i;
        dd    = m_data_o;
        ll    = m_last_o;
        edd   = 'x;
        ell   = 1'b0;
        if (fired) begin
            if (exp_q.size() != 0) edd = exp_q.pop_front();
            ell      = (beat_cnt == PL - 1);
            beat_cnt = (beat_cnt + 1) % PL;
        end
        if (!r && read_en_o && !rempty_i) begin
            pend_word = fifo_q.pop_front();
            pend_pop  = 1'b1;
            exp_q.push_back(pend_word);
            total_pops++;
        end
        if (r) begin
            exp_q.delete();
            beat_cnt   = 0;
            total_pops = 0;
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(next_val);
            next_val++;
        end
    endtask

    task automatic reset_dut();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1, f, d, l, ed, el);
        fifo_q.delete();
        next_val = '0;
    endtask

    task automatic test_reset();
        push_words(4);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 1, 0, f, d, l, ed, el);
            checks++;
            if (read_en_o !== 1'b0) begin errors++; $display("FAIL reset_read_en got %0b exp 0", read_en_o); end
        end
        checks++;
        if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", m_valid_o); end
        checks++;
        if (word_count_o !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", word_count_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
        checks++;
        if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %0b exp 0", m_last_o); end
        checks++;
        if (m_data_o !== '0) begin errors++; $display("FAIL reset_data got %0h exp 0", m_data_o); end
        fifo_q.delete();
        next_val = '0;
    endtask

    task automatic test_streaming();
        int nbeats = 0, nlast = 0, first_c = -1, last_c = -1;
        reset_dut();
        push_words(40);
        for (int c = 0; c < 50; c++) begin
            tick(0, 1, 1, 0, f, d, l, ed, el);
            if (f) begin
                checks++;
                if (d !== ed || l !== el) begin
                    errors++;
                    $display("FAIL stream_beat got %0h/%0b exp %0h/%0b", d, l, ed, el);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                nbeats++;
                if (l) nlast++;
            end
        end
        checks++;
        if (first_c != 2) begin errors++; $display("FAIL stream_latency got %0d exp 2", first_c); end
        checks++;
        if (nbeats != 40 || last_c != 41) begin
            errors++;
            $display("FAIL stream_b2b got beats %0d end %0d exp beats 40 end 41", nbeats, last_c);
        end
        checks++;
        if (nlast != 2) begin errors++; $display("FAIL stream_nlast got %0d exp 2", nlast); end
        checks++;
        if (word_count_o !== 6'd40) begin errors++; $display("FAIL stream_count got %0d exp 40", word_count_o); end
    endtask

    task automatic test_backpressure();
        int nbeats = 0;
        logic [DW-1:0] hold_d;
        reset_dut();
        push_words(30);
        for (int c = 0; c < 6; c++) begin
            tick(0, 1, 1, 0, f, d, l, ed, el);
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed || l !== el) begin errors++; $display("FAIL bp_pre got %0h exp %0h", d, ed); end
            end
        end
        tick(0, 0, 1, 0, f, d, l, ed, el);
        hold_d = m_data_o;
        for (int c = 0; c < 19; c++) begin
            tick(0, 0, 1, 0, f, d, l, ed, el);
            checks++;
            if (m_valid_o !== 1'b1 || m_data_o !== hold_d) begin
                errors++;
                $display("FAIL bp_hold got %0b/%0h exp 1/%0h", m_valid_o, m_data_o, hold_d);
            end
        end
        checks++;
        if (read_en_o !== 1'b0 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL bp_full got rd %0b held %0d exp rd 0 held 2", read_en_o, exp_q.size());
        end
        for (int c = 0; c < 40; c++) begin
            tick(0, 1, 1, 0, f, d, l, ed, el);
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed || l !== el) begin errors++; $display("FAIL bp_post got %0h exp %0h", d, ed); end
            end
        end
        checks++;
        if (nbeats != 30) begin errors++; $display("FAIL bp_total got %0d exp 30", nbeats); end
    endtask

    task automatic test_underrun();
        int nbeats = 0, nlast = 0;
        logic [DW-1:0] last_d = '0;
        reset_dut();
        push_words(6);
        for (int c = 0; c < 12; c++) begin
            tick(0, 1, 1, 0, f, d, l, ed, el);
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed || l !== el) begin errors++; $display("FAIL ur_pre got %0h exp %0h", d, ed); end
            end
        end
        checks++;
        if (m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ur_drained got valid %0b busy %0b exp 0 0", m_valid_o, busy_o);
        end
        push_words(15);
        for (int c = 0; c < 25; c++) begin
            tick(0, 1, 1, 0, f, d, l, ed, el);
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed || l !== el) begin errors++; $display("FAIL ur_post got %0h/%0b exp %0h/%0b", d, l, ed, el); end
                if (l) begin nlast++; last_d = d; end
            end
        end
        checks++;
        if (nbeats != 21 || nlast != 1 || last_d !== 32'd15) begin
            errors++;
            $display("FAIL ur_frame got beats %0d lasts %0d last %0d exp 21 1 15", nbeats, nlast, last_d);
        end
    endtask

    task automatic test_enable();
        int nbeats = 0;
        reset_dut();
        push_words(10);
        tick(0, 0, 1, 0, f, d, l, ed, el);
        checks++;
        if (read_en_o !== 1'b1) begin errors++; $display("FAIL en_issue got %0b exp 1", read_en_o); end
        for (int c = 0; c < 6; c++) begin
            tick(0, 1, 0, 0, f, d, l, ed, el);
            checks++;
            if (read_en_o !== 1'b0) begin errors++; $display("FAIL en_off_read got %0b exp 0", read_en_o); end
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed) begin errors++; $display("FAIL en_off_data got %0h exp %0h", d, ed); end
            end
        end
        checks++;
        if (nbeats != 1 || word_count_o !== 6'd1) begin
            errors++;
            $display("FAIL en_frozen got beats %0d count %0d exp 1 1", nbeats, word_count_o);
        end
        for (int c = 0; c < 20; c++) begin
            tick(0, 1, 1, 0, f, d, l, ed, el);
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed || l !== el) begin errors++; $display("FAIL en_on got %0h exp %0h", d, ed); end
            end
        end
        checks++;
        if (nbeats != 10 || word_count_o !== 6'd10) begin
            errors++;
            $display("FAIL en_resume got beats %0d count %0d exp 10 10", nbeats, word_count_o);
        end
    endtask

    task automatic test_reset_midop();
        int dropped, nbeats = 0;
        reset_dut();
        push_words(20);
        for (int c = 0; c < 3; c++) tick(0, 0, 1, 0, f, d, l, ed, el);
        dropped = exp_q.size();
        checks++;
        if (dropped != 2 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill got held %0d busy %0b exp 2 1", dropped, busy_o);
        end
        tick(1, 1, 1, 0, f, d, l, ed, el);
        tick(1, 1, 1, 0, f, d, l, ed, el);
        checks++;
        if ({m_valid_o, busy_o, m_last_o, read_en_o} !== 4'b0 || word_count_o !== '0 || m_data_o !== '0) begin
            errors++;
            $display("FAIL mid_reset got v%0b b%0b l%0b r%0b cnt %0d data %0h exp all 0",
                     m_valid_o, busy_o, m_last_o, read_en_o, word_count_o, m_data_o);
        end
        for (int c = 0; c < 30; c++) begin
            tick(0, 1, 1, 0, f, d, l, ed, el);
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed || l !== el) begin errors++; $display("FAIL mid_post got %0h/%0b exp %0h/%0b", d, l, ed, el); end
            end
        end
        checks++;
        if (nbeats != 18 || word_count_o !== 6'd18) begin
            errors++;
            $display("FAIL mid_resume got beats %0d count %0d exp 18 18", nbeats, word_count_o);
        end
    endtask

    task automatic test_random();
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        int nbeats = 0, lim;
        bit r, rdy, en, hold;
        reset_dut();
        for (int c = 0; c < 10000; c++) begin
            if (fifo_q.size() < 32 && ($urandom % 3) != 0) begin
                fifo_q.push_back(DW'($urandom));
            end
            r    = (c > 100) && (($urandom % 1500) == 0);
            rdy  = ($urandom % 4) != 0;
            en   = ($urandom % 10) != 0;
            hold = ($urandom % 5) == 0;
            tick(r, rdy, en, hold, f, d, l, ed, el);
            if (prev_stall) begin
                checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== prev_d) begin
                    errors++;
                    $display("FAIL rnd_stable cycle %0d got %0b/%0h exp 1/%0h", c, m_valid_o, m_data_o, prev_d);
                end
            end
            if (f) begin
                nbeats++;
                checks++;
                if (d !== ed || l !== el) begin
                    errors++;
                    $display("FAIL rnd_beat cycle %0d got %0h/%0b exp %0h/%0b", c, d, l, ed, el);
                end
            end
            checks++;
            if (exp_q.size() > 2) begin
                errors++;
                $display("FAIL rnd_overcommit cycle %0d got %0d exp <=2", c, exp_q.size());
            end
            prev_stall = !r && m_valid_o && !rdy;
            prev_d     = m_data_o;
        end
        lim = (total_pops > CMAX) ? CMAX : total_pops;
        checks++;
        if (word_count_o !== CW'(lim)) begin
            errors++;
            $display("FAIL rnd_count got %0d exp %0d", word_count_o, lim);
        end
        checks++;
        if (nbeats < 1000) begin errors++; $display("FAIL rnd_progress got %0d exp >=1000", nbeats); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_underrun();
        test_enable();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
